randomizer: RTL and testbench



---
 rtl/randomizer_if.sv | 17 +
 rtl/randomizer.sv | 44 ++++
 tb/tb_randomizer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/randomizer_if.sv
// rtl/randomizer_if.sv - serial scrambler data/control bundle; out_valid present under RANDOMIZER_VALID_EN
interface randomizer_if;
    logic        load;
    logic        in;
    logic        enable;
    logic [14:0] seed;
    logic        out;
`ifdef RANDOMIZER_VALID_EN
    logic        out_valid;

    modport master (output load, in, enable, seed, input out, out_valid);
    modport slave  (input load, in, enable, seed, output out, out_valid);
`else
    modport master (output load, in, enable, seed, input out);
    modport slave  (input load, in, enable, seed, output out);
`endif
endinterface

// File: rtl/randomizer.sv
// rtl/randomizer.sv - bit-serial 1+x^14+x^15 PRBS scrambler/descrambler; optional out_valid via RANDOMIZER_VALID_EN
module randomizer #(
    parameter logic [14:0] SEED_RST = 15'h3715
) (
    input  logic         clk,
    input  logic         reset,
    randomizer_if.slave  bus
);
    // r[14] is stage 1 (feedback entry), r[0] is stage 15 (oldest bit)
    logic [14:0] r;
    logic        out_q;
    logic        p;

    assign p       = r[1] ^ r[0];
    assign bus.out = out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r     <= SEED_RST;
            out_q <= 1'b0;
        end else if (bus.load) begin
            // frame start: the incoming bit is dropped even if enable is high
            r     <= bus.seed;
            out_q <= 1'b0;
        end else if (bus.enable) begin
            r     <= {p, r[14:1]};
            out_q <= bus.in ^ p;
        end
    end

`ifdef RANDOMIZER_VALID_EN
    logic valid_q;

    assign bus.out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (reset || bus.load) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.enable;
        end
    end
`endif
endmodule

// File: tb/tb_randomizer.sv
// tb/tb_randomizer.sv - self-checking bench for randomizer (table vectors, known frames, random vs PRBS recurrence model)
module tb_randomizer;
    localparam logic [14:0] SEED_DEF = 15'h3715;
    localparam logic [95:0] PLAIN    = 96'hACBCD2114DAE1577C6DBF4C9;
    localparam logic [95:0] SCRAM    = 96'h558AC4A53A1724E163AC2BF9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    randomizer_if bus ();

    randomizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: PRBS as a sliding window h of the last 15 sequence bits, oldest first.
    // Each new bit is h[n] ^ h[n+1] and is also the keystream bit for that step.
    bit h[$];
    bit m_out;
    bit m_valid;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check96(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_seed(input logic [14:0] s);
        h = {};
        for (int i = 0; i < 15; i++) h.push_back(s[i]);
    endtask

    task automatic step(input string name);
        bit p;
        if (reset) begin
            model_seed(SEED_DEF);
            m_out = 0;
            m_valid = 0;
        end else if (bus.load) begin
            model_seed(bus.seed);
            m_out = 0;
            m_valid = 0;
        end else begin
            m_valid = bus.enable;
            if (bus.enable) begin
                p = h[0] ^ h[1];
                m_out = bus.in ^ p;
                h.push_back(p);
                void'(h.pop_front());
            end
        end
        @(posedge clk);
        #1;
        check(name, bus.out, m_out);
`ifdef RANDOMIZER_VALID_EN
        check({name, "_valid"}, bus.out_valid, m_valid);
`endif
    endtask

    task automatic idle_inputs();
        reset      = 0;
        bus.load   = 0;
        bus.enable = 0;
        bus.in     = 0;
        bus.seed   = '0;
    endtask

    task automatic do_load(input logic [14:0] s);
        bus.load = 1; bus.seed = s; bus.enable = 1; bus.in = 1;
        step("load");
        check("load_out_zero", bus.out, 1'b0);
        idle_inputs();
    endtask

    task automatic run_frame(input logic [95:0] data, input int stall_at, input int stall_len,
                             output logic [95:0] res);
        logic held;
        for (int i = 0; i < 96; i++) begin
            if (i == stall_at) begin
                held = bus.out;
                for (int k = 0; k < stall_len; k++) begin
                    bus.enable = 0; bus.in = 1'($urandom);
                    step("stall");
                    check("stall_hold", bus.out, held);
                end
            end
            bus.enable = 1; bus.in = data[95-i];
            step("frame_bit");
            res[95-i] = bus.out;
        end
        bus.enable = 0;
    endtask

    typedef struct {
        logic        rst;
        logic        ld;
        logic        en;
        logic        din;
        logic [14:0] seed;
        logic        exp_out;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [95:0] res;

        idle_inputs();
        reset = 1;
        step("reset");
        check("reset_out", bus.out, 1'b0);
        reset = 0;

        // 1: reference frame, first three outs 0,1,0
        do_load(SEED_DEF);
        bus.enable = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in = PLAIN[95-i];
            step("t1_head");
            res[95-i] = bus.out;
        end
        check("t1_first0", res[95], 1'b0);
        check("t1_first1", res[94], 1'b1);
        check("t1_first2", res[93], 1'b0);
        do_load(SEED_DEF);
        run_frame(PLAIN, -1, 0, res);
        check96("t1_frame", res, SCRAM);

        // 2: stall mid-frame
        do_load(SEED_DEF);
        run_frame(PLAIN, 50, 5, res);
        check96("t2_stall_frame", res, SCRAM);

        // 3: load pulse at bit 40, then full restart
        do_load(SEED_DEF);
        bus.enable = 1;
        for (int i = 0; i < 40; i++) begin
            bus.in = PLAIN[95-i];
            step("t3_pre");
        end
        do_load(SEED_DEF);
        run_frame(PLAIN, -1, 0, res);
        check96("t3_frame", res, SCRAM);

        // 4: round trip
        do_load(SEED_DEF);
        run_frame(SCRAM, -1, 0, res);
        check96("t4_roundtrip", res, PLAIN);

        // 5: reset and load together mid-frame; reset wins
        do_load(15'h1234);
        bus.enable = 1;
        for (int i = 0; i < 30; i++) begin
            bus.in = 1'($urandom);
            step("t5_pre");
        end
        reset = 1; bus.load = 1; bus.seed = 15'h5A5A;
        step("t5_rst_load");
        check("t5_out_zero", bus.out, 1'b0);
        idle_inputs();
        run_frame(PLAIN, -1, 0, res);
        check96("t5_frame", res, SCRAM);

        // 6: zero seed is pass-through, plus X on ignored inputs
        vecs[0] = '{0, 1, 1'bx, 1'bx, 15'h0000, 0};
        vecs[1] = '{0, 0, 1, 1, 15'hxxxx, 1};
        vecs[2] = '{0, 0, 1, 0, 15'hxxxx, 0};
        vecs[3] = '{0, 0, 1, 1, 15'hxxxx, 1};
        vecs[4] = '{0, 0, 1, 1, 15'hxxxx, 1};
        vecs[5] = '{0, 0, 0, 1'bx, 15'hxxxx, 1};
        vecs[6] = '{0, 0, 1, 0, 15'hxxxx, 0};
        vecs[7] = '{1, 1'bx, 1'bx, 1'bx, 15'hxxxx, 0};
        vecs[8] = '{0, 0, 1, 1, 15'hxxxx, 0};
        vecs[9] = '{0, 0, 1, 0, 15'hxxxx, 1};
        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst; bus.load = vecs[i].ld; bus.enable = vecs[i].en;
            bus.in = vecs[i].din; bus.seed = vecs[i].seed;
            step("vec");
            check($sformatf("vec%0d", i), bus.out, vecs[i].exp_out);
        end
        idle_inputs();

        // randomized traffic against the recurrence model
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            bus.load   = ($urandom_range(0, 19) == 0);
            bus.enable = ($urandom_range(0, 3) != 0);
            bus.in     = 1'($urandom);
            bus.seed   = ($urandom_range(0, 9) == 0) ? 15'h0 : 15'($urandom);
            step("random");
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
